button_conditioner: RTL and testbench

Input stage that sits directly upstream of the guitar_hero top and feeds it the fret buttons.
- Synchronises the raw active-low fret buttons into the clock domain and debounces each lane.
- Produces active-high levels and one-cycle press pulses.
- Accumulates presses into per-note-window hit masks, framed by the shifter's note tick.
- The equality checker and score logic consume these clean hit masks instead of raw button levels.

---
 rtl/gh_pkg.sv | 8 +
 rtl/debounce_lane.sv | 55 +++++
 rtl/button_conditioner.sv | 73 +++++++
 tb/tb_button_conditioner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gh_pkg.sv
// Shared definitions for the guitar_hero datapath: lane count, lane mask type
// and the default debounce interval.
package gh_pkg;
  localparam int GH_LANES            = 4;
  localparam int GH_DEBOUNCE_DEFAULT = 1000000;

  typedef logic [GH_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/debounce_lane.sv
// One fret lane: two-flop synchroniser, stability counter, debounced level and
// a one-cycle pulse on each debounced press.
module debounce_lane
  import gh_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GH_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);
  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q;
  logic             s;

  // Synchroniser holds the raw active-low value, so "released" is all ones.
  assign s = ~sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/button_conditioner.sv
// Fret input stage: per-lane debounce plus a note-window accumulator that
// reports which lanes were pressed (and whether any twice) in each window.
module button_conditioner
  import gh_pkg::*;
#(
  parameter int LANES           = GH_LANES,
  parameter int DEBOUNCE_CYCLES = GH_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] btn_n,
  input  logic             window_tick,
  output logic [LANES-1:0] level,
  output logic [LANES-1:0] press,
  output logic [LANES-1:0] hits,
  output logic             hits_valid,
  output logic             hits_dup
);
  logic [LANES-1:0] acc_q, acc_d, acc_closed;
  logic [LANES-1:0] hits_q, hits_d;
  logic             dup_q, dup_d, dup_closed;
  logic             hits_dup_q, hits_dup_d;
  logic             hits_valid_q, hits_valid_d;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[g]),
      .level (level[g]),
      .press (press[g])
    );
  end

  // A press landing on the tick cycle still belongs to the closing window.
  assign acc_closed = acc_q | press;
  assign dup_closed = dup_q | (|(acc_q & press));

  always_comb begin
    acc_d        = acc_closed;
    dup_d        = dup_closed;
    hits_d       = hits_q;
    hits_dup_d   = hits_dup_q;
    hits_valid_d = 1'b0;
    if (window_tick) begin
      hits_d       = acc_closed;
      hits_dup_d   = dup_closed;
      hits_valid_d = 1'b1;
      acc_d        = '0;
      dup_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q        <= '0;
      dup_q        <= 1'b0;
      hits_q       <= '0;
      hits_dup_q   <= 1'b0;
      hits_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      dup_q        <= dup_d;
      hits_q       <= hits_d;
      hits_dup_q   <= hits_dup_d;
      hits_valid_q <= hits_valid_d;
    end
  end

  assign hits       = hits_q;
  assign hits_valid = hits_valid_q;
  assign hits_dup   = hits_dup_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a per-cycle behavioural model
// (sample history and per-window press counts) plus literal spot checks.
module tb_button_conditioner;
  localparam int L = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [L-1:0] btn_n;
  logic         window_tick;
  logic [L-1:0] level, press, hits;
  logic         hits_valid, hits_dup;

  button_conditioner #(.LANES(L), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .window_tick (window_tick),
    .level       (level),
    .press       (press),
    .hits        (hits),
    .hits_valid  (hits_valid),
    .hits_dup    (hits_dup)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  logic [L-1:0] m_s1, m_s2, m_level, m_press, m_hits;
  logic         m_valid, m_dup;
  logic [D-1:0] hist [L];
  int           age  [L];
  int           pcnt [L];
  bit           model_ok = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
        m_hits = '0; m_valid = 1'b0; m_dup = 1'b0;
        for (int i = 0; i < L; i++) begin hist[i] = '0; age[i] = 0; pcnt[i] = 0; end
        model_ok = 1'b1;
      end else if (model_ok) begin
        // Window: count presses per lane, report on tick.
        for (int i = 0; i < L; i++) pcnt[i] += int'(m_press[i]);
        if (window_tick) begin
          m_dup = 1'b0;
          for (int i = 0; i < L; i++) begin
            m_hits[i] = (pcnt[i] > 0);
            if (pcnt[i] > 1) m_dup = 1'b1;
            pcnt[i] = 0;
          end
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
        // Debounce: flip once the last D synchronised samples all disagree.
        m_press = '0;
        for (int i = 0; i < L; i++) begin
          hist[i] = {hist[i][D-2:0], m_s2[i]};
          age[i]++;
          if (age[i] >= D && hist[i] == {D{~m_level[i]}}) begin
            m_level[i] = ~m_level[i];
            m_press[i] = m_level[i];
            age[i] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = ~btn_n;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      total++;
      if ({level, press, hits, hits_valid, hits_dup} !==
          {m_level, m_press, m_hits, m_valid, m_dup}) begin
        bad++;
        $display("FAIL model t=%0t dut lvl=%b prs=%b hits=%b v=%b d=%b want lvl=%b prs=%b hits=%b v=%b d=%b",
                 $time, level, press, hits, hits_valid, hits_dup,
                 m_level, m_press, m_hits, m_valid, m_dup);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    window_tick = 1'b1;
    cyc(1);
    window_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; btn_n = 4'b0000; window_tick = 1'b0;
    // 1. reset hold, then lane 0 held through release
    cyc(3);
    chk("rst_out", {level, press}, 8'h00);
    chk("rst_hits", {hits, 1'b0, 1'b0, hits_valid, hits_dup}, 8'h00);
    reset = 1'b1; btn_n = 4'b1110;
    cyc(5);
    chk("t1_lvl_c5", {7'b0, level[0]}, 8'h00);
    cyc(1);
    chk("t1_lvl_c6", {6'b0, level[0], press[0]}, 8'h03);
    cyc(1);
    chk("t1_prs_c7", {7'b0, press[0]}, 8'h00);

    // 2. lane 1 bounces with 2-cycle runs, then settles pressed
    for (int k = 0; k < 10; k++) begin
      btn_n[1] = ~btn_n[1];
      cyc(2);
      chk("t2_bounce", {7'b0, level[1]}, 8'h00);
    end
    btn_n[1] = 1'b0;
    cyc(5);
    chk("t2_c5", {6'b0, level[1], press[1]}, 8'h00);
    cyc(1);
    chk("t2_c6", {6'b0, level[1], press[1]}, 8'h03);
    cyc(1);
    chk("t2_c7", {7'b0, press[1]}, 8'h00);
    btn_n = 4'b1111;
    cyc(8);
    tick();
    cyc(2);

    // 3. lanes 0 and 2 in one window
    btn_n = 4'b1010; cyc(8);
    btn_n = 4'b1111; cyc(8);
    tick();
    chk("t3_hits", {hits, 2'b0, hits_valid, hits_dup}, 8'h52);
    cyc(1);
    chk("t3_vld_off", {7'b0, hits_valid}, 8'h00);
    cyc(4);
    tick();
    chk("t3_empty", {hits, 2'b0, hits_valid, hits_dup}, 8'h02);

    // 4. press[3] coincident with the tick
    btn_n = 4'b0111;
    cyc(6);
    chk("t4_prs", {4'b0, press}, 8'h08);
    tick();
    chk("t4_hits", {hits, 2'b0, hits_valid, hits_dup}, 8'h82);
    btn_n = 4'b1111; cyc(8);
    tick();
    chk("t4_empty", {hits, 2'b0, hits_valid, hits_dup}, 8'h02);

    // 5. lane 3 pressed twice in one window
    btn_n = 4'b0111; cyc(8);
    btn_n = 4'b1111; cyc(8);
    btn_n = 4'b0111; cyc(8);
    btn_n = 4'b1111; cyc(8);
    tick();
    chk("t5_dup", {hits, 2'b0, hits_valid, hits_dup}, 8'h83);
    cyc(3);
    tick();
    chk("t5_clean", {hits, 2'b0, hits_valid, hits_dup}, 8'h02);

    // 6. reset while lane 2's counter sits at 3
    btn_n = 4'b1011;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("t6_after_rst", {6'b0, level[2], press[2]}, 8'h00);
    cyc(5);
    chk("t6_c5", {7'b0, level[2]}, 8'h00);
    cyc(1);
    chk("t6_c6", {6'b0, level[2], press[2]}, 8'h03);

    // back-to-back ticks and a held tick, checked by the model
    btn_n = 4'b1111; cyc(8);
    btn_n = 4'b1110;
    window_tick = 1'b1;
    cyc(10);
    window_tick = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
